// File: rtl/uvmt_cv32e40x_pma_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// uvmt_cv32e40x_pma_lookup_arbiter
//
// Arbitrates between an instruction-side and a data-side requester for a
// single shared combinational PMA model. One request is served at a time:
// it is granted in IDLE, looked up in LOOK1 (and LOOK2 for a misaligned
// data access that spills into the next word), and reported in RESP until
// the consumer accepts the response.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req_*                   instruction-side request (valid/ready, addr, dbg)
//   d_req_*                   data-side request (valid/ready, addr, dbg, load,
//                             misaligned, pushpop)
//   pma_*_o                   lookup drive to the shared PMA model
//   pma_allow_i, pma_main_i   same-cycle PMA model result
//   rsp_*                     response (valid/ready, owner, merged allow/main,
//                             split flag)
// ---------------------------------------------------------------------------
module uvmt_cv32e40x_pma_lookup_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_dbg,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_dbg,
  input  logic        d_req_load,
  input  logic        d_req_misaligned,
  input  logic        d_req_pushpop,
  output logic [31:0] pma_addr_o,
  output logic        pma_dbg_o,
  output logic        pma_load_o,
  output logic        pma_misaligned_o,
  output logic        pma_pushpop_o,
  output logic        pma_is_instr_o,
  input  logic        pma_allow_i,
  input  logic        pma_main_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_is_instr_o,
  output logic        rsp_allow_o,
  output logic        rsp_main_o,
  output logic        rsp_split_o
);

  typedef enum logic [1:0] {IDLE, LOOK1, LOOK2, RESP} state_t;

  state_t      state;
  logic        last_data;
  logic [31:0] addr_q;
  logic        dbg_q;
  logic        load_q;
  logic        mis_q;
  logic        pushpop_q;
  logic        is_instr_q;
  logic        allow_q;
  logic        main_q;

  logic        grant_instr;
  logic        grant_data;
  logic        need_split;
  logic [31:0] next_word_addr;

  // Round-robin grant: on a tie the side not served last wins. Readies are
  // combinational so the handshake completes in the IDLE cycle itself, and
  // they are held low while reset is asserted.
  always_comb begin
    grant_instr    = 1'b0;
    grant_data     = 1'b0;
    need_split     = 1'b0;
    next_word_addr = 32'd0;
    if (state == IDLE && !rst) begin
      grant_instr = i_req_valid && (!d_req_valid || last_data);
      grant_data  = d_req_valid && (!i_req_valid || !last_data);
    end
    // A misaligned data access with a non-zero byte offset crosses into the
    // following word, which needs its own lookup; the add wraps at 2^32.
    need_split     = !is_instr_q && mis_q && (addr_q[1:0] != 2'b00);
    next_word_addr = {addr_q[31:2], 2'b00} + 32'd4;
  end

  assign i_req_ready = grant_instr;
  assign d_req_ready = grant_data;

  // Main FSM. The PMA drive and the response are registered outputs that are
  // loaded on entry to the state that presents them and cleared on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last_data        <= 1'b1;
      addr_q           <= 32'd0;
      dbg_q            <= 1'b0;
      load_q           <= 1'b0;
      mis_q            <= 1'b0;
      pushpop_q        <= 1'b0;
      is_instr_q       <= 1'b0;
      allow_q          <= 1'b0;
      main_q           <= 1'b0;
      pma_addr_o       <= 32'd0;
      pma_dbg_o        <= 1'b0;
      pma_load_o       <= 1'b0;
      pma_misaligned_o <= 1'b0;
      pma_pushpop_o    <= 1'b0;
      pma_is_instr_o   <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_is_instr_o   <= 1'b0;
      rsp_allow_o      <= 1'b0;
      rsp_main_o       <= 1'b0;
      rsp_split_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_instr) begin
            // Instruction fetches never carry data-side attributes.
            addr_q           <= i_req_addr;
            dbg_q            <= i_req_dbg;
            load_q           <= 1'b0;
            mis_q            <= 1'b0;
            pushpop_q        <= 1'b0;
            is_instr_q       <= 1'b1;
            last_data        <= 1'b0;
            pma_addr_o       <= i_req_addr;
            pma_dbg_o        <= i_req_dbg;
            pma_load_o       <= 1'b0;
            pma_misaligned_o <= 1'b0;
            pma_pushpop_o    <= 1'b0;
            pma_is_instr_o   <= 1'b1;
            state            <= LOOK1;
          end else if (grant_data) begin
            addr_q           <= d_req_addr;
            dbg_q            <= d_req_dbg;
            load_q           <= d_req_load;
            mis_q            <= d_req_misaligned;
            pushpop_q        <= d_req_pushpop;
            is_instr_q       <= 1'b0;
            last_data        <= 1'b1;
            pma_addr_o       <= d_req_addr;
            pma_dbg_o        <= d_req_dbg;
            pma_load_o       <= d_req_load;
            pma_misaligned_o <= d_req_misaligned;
            pma_pushpop_o    <= d_req_pushpop;
            pma_is_instr_o   <= 1'b0;
            state            <= LOOK1;
          end
        end
        LOOK1: begin
          allow_q <= pma_allow_i;
          main_q  <= pma_main_i;
          if (need_split) begin
            pma_addr_o <= next_word_addr;
            state      <= LOOK2;
          end else begin
            rsp_valid_o      <= 1'b1;
            rsp_is_instr_o   <= is_instr_q;
            rsp_allow_o      <= pma_allow_i;
            rsp_main_o       <= pma_main_i;
            rsp_split_o      <= 1'b0;
            pma_addr_o       <= 32'd0;
            pma_dbg_o        <= 1'b0;
            pma_load_o       <= 1'b0;
            pma_misaligned_o <= 1'b0;
            pma_pushpop_o    <= 1'b0;
            pma_is_instr_o   <= 1'b0;
            state            <= RESP;
          end
        end
        LOOK2: begin
          // Both words must be allowed / main for the access as a whole.
          rsp_valid_o      <= 1'b1;
          rsp_is_instr_o   <= is_instr_q;
          rsp_allow_o      <= allow_q & pma_allow_i;
          rsp_main_o       <= main_q & pma_main_i;
          rsp_split_o      <= 1'b1;
          pma_addr_o       <= 32'd0;
          pma_dbg_o        <= 1'b0;
          pma_load_o       <= 1'b0;
          pma_misaligned_o <= 1'b0;
          pma_pushpop_o    <= 1'b0;
          pma_is_instr_o   <= 1'b0;
          state            <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o    <= 1'b0;
            rsp_is_instr_o <= 1'b0;
            rsp_allow_o    <= 1'b0;
            rsp_main_o     <= 1'b0;
            rsp_split_o    <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uvmt_cv32e40x_pma_lookup_arbiter
//
// Drives directed and random requests into the PMA lookup arbiter, supplies
// a small address-based PMA model, and compares every observable phase of
// each transaction against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_uvmt_cv32e40x_pma_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_req_dbg;
  logic [31:0] i_req_addr;
  logic        d_req_valid, d_req_ready, d_req_dbg, d_req_load, d_req_misaligned, d_req_pushpop;
  logic [31:0] d_req_addr;
  logic [31:0] pma_addr_o;
  logic        pma_dbg_o, pma_load_o, pma_misaligned_o, pma_pushpop_o, pma_is_instr_o;
  logic        pma_allow_i, pma_main_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_is_instr_o, rsp_allow_o, rsp_main_o, rsp_split_o;

  int   checks = 0;
  int   errors = 0;
  logic last_data_m;

  always #5 clk = ~clk;

  // Address-based PMA model: region with bits 13 and 12 both set is denied;
  // main memory when address bits 4 and 20 agree.
  function automatic logic ref_allow(input logic [31:0] a);
    return !(a[13] && a[12]);
  endfunction

  function automatic logic ref_main(input logic [31:0] a);
    return a[4] == a[20];
  endfunction

  assign pma_allow_i = ref_allow(pma_addr_o);
  assign pma_main_i  = ref_main(pma_addr_o);

  uvmt_cv32e40x_pma_lookup_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (i_req_valid),
    .i_req_ready      (i_req_ready),
    .i_req_addr       (i_req_addr),
    .i_req_dbg        (i_req_dbg),
    .d_req_valid      (d_req_valid),
    .d_req_ready      (d_req_ready),
    .d_req_addr       (d_req_addr),
    .d_req_dbg        (d_req_dbg),
    .d_req_load       (d_req_load),
    .d_req_misaligned (d_req_misaligned),
    .d_req_pushpop    (d_req_pushpop),
    .pma_addr_o       (pma_addr_o),
    .pma_dbg_o        (pma_dbg_o),
    .pma_load_o       (pma_load_o),
    .pma_misaligned_o (pma_misaligned_o),
    .pma_pushpop_o    (pma_pushpop_o),
    .pma_is_instr_o   (pma_is_instr_o),
    .pma_allow_i      (pma_allow_i),
    .pma_main_i       (pma_main_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_is_instr_o   (rsp_is_instr_o),
    .rsp_allow_o      (rsp_allow_o),
    .rsp_main_o       (rsp_main_o),
    .rsp_split_o      (rsp_split_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Everything idle: no readies, no response, no PMA drive.
  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_i_ready"}, i_req_ready, 0);
    checkOutput({tag, "_d_ready"}, d_req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, "_pma_addr"}, pma_addr_o, 0);
    checkOutput({tag, "_pma_attr"}, {pma_dbg_o, pma_load_o, pma_misaligned_o, pma_pushpop_o, pma_is_instr_o}, 0);
  endtask

  // One complete transaction, started from IDLE. The reference model decides
  // the winner, whether a second lookup happens, its address and the merged
  // result; each phase of the DUT is then compared cycle by cycle.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic idbg,
                               input logic dv, input logic [31:0] da, input logic ddbg,
                               input logic dld, input logic dmis, input logic dpp,
                               input int hold);
    logic        gi, split, allow, main, dbg, ld, mis, pp;
    logic [31:0] a1, a2;
    @(negedge clk);
    i_req_valid = iv; i_req_addr = ia; i_req_dbg = idbg;
    d_req_valid = dv; d_req_addr = da; d_req_dbg = ddbg;
    d_req_load = dld; d_req_misaligned = dmis; d_req_pushpop = dpp;
    rsp_ready_i = 1'b0;
    gi = iv && (!dv || last_data_m);
    if (gi) begin
      a1 = ia; dbg = idbg; ld = 0; mis = 0; pp = 0; split = 0;
    end else begin
      a1 = da; dbg = ddbg; ld = dld; mis = dmis; pp = dpp;
      split = dmis && ((da % 4) != 0);
    end
    a2    = a1 - (a1 % 4) + 32'd4;
    allow = ref_allow(a1) && (!split || ref_allow(a2));
    main  = ref_main(a1) && (!split || ref_main(a2));
    #1;
    checkOutput("grant_i_ready", i_req_ready, gi);
    checkOutput("grant_d_ready", d_req_ready, !gi);
    last_data_m = !gi;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("look1_addr", pma_addr_o, a1);
    checkOutput("look1_attr", {pma_dbg_o, pma_load_o, pma_misaligned_o, pma_pushpop_o, pma_is_instr_o},
                {dbg, ld, mis, pp, gi});
    checkOutput("look1_readies", {i_req_ready, d_req_ready}, 0);
    checkOutput("look1_rsp_valid", rsp_valid_o, 0);
    if (split) begin
      @(negedge clk);
      checkOutput("look2_addr", pma_addr_o, a2);
      checkOutput("look2_attr", {pma_dbg_o, pma_load_o, pma_misaligned_o, pma_pushpop_o, pma_is_instr_o},
                  {dbg, ld, mis, pp, 1'b0});
      checkOutput("look2_rsp_valid", rsp_valid_o, 0);
    end
    @(negedge clk);
    checkOutput("rsp_valid", rsp_valid_o, 1);
    checkOutput("rsp_fields", {rsp_is_instr_o, rsp_allow_o, rsp_main_o, rsp_split_o}, {gi, allow, main, split});
    checkOutput("rsp_pma_idle", {pma_addr_o, pma_is_instr_o}, 0);
    for (int k = 0; k < hold; k++) begin
      if (k == 0) begin
        i_req_valid = 1'b1; d_req_valid = 1'b1;
      end
      #1;
      checkOutput("hold_readies", {i_req_ready, d_req_ready}, 0);
      @(negedge clk);
      checkOutput("hold_rsp_valid", rsp_valid_o, 1);
      checkOutput("hold_rsp_fields", {rsp_is_instr_o, rsp_allow_o, rsp_main_o, rsp_split_o}, {gi, allow, main, split});
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rsp_valid", rsp_valid_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0; i_req_dbg = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_dbg = 1'b0;
    d_req_load = 1'b0; d_req_misaligned = 1'b0; d_req_pushpop = 1'b0;
    rsp_ready_i = 1'b0;
    last_data_m = 1'b1;

    // Reset state with both requests pending.
    repeat (2) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_rsp_fields", {rsp_is_instr_o, rsp_allow_o, rsp_main_o, rsp_split_o}, 0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rst = 1'b0;

    // Eight back-to-back ties: instruction first, then strict alternation.
    for (int n = 0; n < 8; n++)
      applyStimulus(1, $urandom & 32'hFFFF_FFFC, 0, 1, $urandom, 1, 1, 0, 1, 0);

    // Single instruction lookup, then a split data lookup across 0x3000.
    applyStimulus(1, 32'h0000_1000, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 1, 32'h0000_2FFE, 0, 1, 1, 0, 0);
    // Address wrap on the second lookup.
    applyStimulus(0, 32'h0, 0, 1, 32'hFFFF_FFFD, 1, 0, 1, 1, 0);
    // Misaligned flag with aligned address, and misaligned-looking instr.
    applyStimulus(0, 32'h0, 0, 1, 32'h0000_4000, 0, 1, 1, 0, 0);
    applyStimulus(1, 32'h0000_5003, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    // Backpressure for five cycles.
    applyStimulus(0, 32'h0, 0, 1, 32'h0000_3001, 0, 0, 1, 0, 5);

    // Reset during LOOK2 of a split data lookup aborts it.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h0000_2FFE; d_req_misaligned = 1'b1;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_look2_addr", pma_addr_o, 32'h0000_3000);
    #1;
    rst = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    checkQuiet("abort_in_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    last_data_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkQuiet("abort_after");
    end
    applyStimulus(0, 32'h0, 0, 1, 32'h0000_0100, 0, 1, 0, 0, 0);

    // Last grant instruction, then reset in IDLE: next tie goes to instruction.
    applyStimulus(1, 32'h0000_0200, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_data_m = 1'b1;
    applyStimulus(1, 32'h0000_0300, 0, 1, 32'h0000_0401, 0, 0, 1, 0, 0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      logic iv, dv;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) dv = 1'b1;
      applyStimulus(iv, $urandom, 1'($urandom_range(0, 1)),
                    dv, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
